run_length_detector: RTL and testbench

//  Parametrised successor of the 2-bit ones-run FSM. Measures runs of consecutive 1s on a

---
 rtl/rld_pkg.sv | 16 +
 rtl/rld_out_buf.sv | 57 +++++
 rtl/run_length_detector.sv | 96 +++++++++
 tb/tb_run_length_detector.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/rld_pkg.sv
// rld_pkg: shared states, helpers and widths for the run-length detector.
package rld_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        SAT  = 2'b10
    } rld_state_t;

    localparam int DROP_CNT_W = 8;

    function automatic int max_run(input int cnt_w);
        return (1 << cnt_w) - 1;
    endfunction

endpackage

// File: rtl/rld_out_buf.sv
// rld_out_buf: one-entry valid/ready report buffer with drop pulse.
// RLD_DROP_CNT_EN adds a saturating drop counter cleared on accept.
module rld_out_buf
    import rld_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [CNT_W-1:0] len,
    input  logic             sat,
    input  logic             len_ready,
    output logic [CNT_W-1:0] len_o,
    output logic             sat_o,
    output logic             len_valid,
    output logic             drop_o
`ifdef RLD_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

    logic accept, drop, load;

    assign accept = len_valid && len_ready;
    assign drop   = push && len_valid && !len_ready;
    assign load   = push && !drop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_o     <= '0;
            sat_o     <= 1'b0;
            len_valid <= 1'b0;
            drop_o    <= 1'b0;
        end else begin
            if (load) begin
                len_o <= len;
                sat_o <= sat;
            end
            len_valid <= load || (len_valid && !accept);
            drop_o    <= drop;
        end
    end

`ifdef RLD_DROP_CNT_EN
    // a drop needs !len_ready, so it never coincides with an accept
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            drop_cnt <= '0;
        else
            drop_cnt <= accept ? '0 :
                        (drop && drop_cnt != '1) ? drop_cnt + 1'b1 : drop_cnt;
    end
`endif

endmodule

// File: rtl/run_length_detector.sv
// run_length_detector: measures runs of 1s on b (qualified by b_en) and reports lengths.
// RLD_DROP_CNT_EN adds output drop_cnt.
module run_length_detector
    import rld_pkg::*;
#(
    parameter int CNT_W   = 4,
    parameter int MIN_RUN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             b,
    input  logic             b_en,
    output logic [CNT_W-1:0] len_o,
    output logic             sat_o,
    output logic             len_valid,
    input  logic             len_ready,
    output logic             drop_o
`ifdef RLD_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

    localparam logic [CNT_W-1:0] MAX = CNT_W'(max_run(CNT_W));
    localparam logic [CNT_W-1:0] MIN = CNT_W'(MIN_RUN);

    rld_state_t       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, fin_len;
    logic             fin, fin_sat, push;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        fin     = 1'b0;
        fin_len = cnt;
        fin_sat = 1'b0;
        if (b_en) begin
            unique case (state)
                IDLE: if (b) begin
                    cnt_n   = CNT_W'(1);
                    state_n = (MAX == CNT_W'(1)) ? SAT : RUN;
                end
                RUN: if (b) begin
                    cnt_n   = cnt + CNT_W'(1);
                    state_n = (cnt + CNT_W'(1) == MAX) ? SAT : RUN;
                end else begin
                    fin     = 1'b1;
                    cnt_n   = '0;
                    state_n = IDLE;
                end
                SAT: if (!b) begin
                    fin     = 1'b1;
                    fin_len = MAX;
                    fin_sat = 1'b1;
                    cnt_n   = '0;
                    state_n = IDLE;
                end
                default: begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end
            endcase
        end
    end

    // runs shorter than MIN_RUN vanish without touching the buffer
    assign push = fin && (fin_len >= MIN);

    rld_out_buf #(.CNT_W(CNT_W)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .len       (fin_len),
        .sat       (fin_sat),
        .len_ready (len_ready),
        .len_o     (len_o),
        .sat_o     (sat_o),
        .len_valid (len_valid),
        .drop_o    (drop_o)
`ifdef RLD_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

endmodule

// File: tb/tb_run_length_detector.sv
// tb_run_length_detector: directed vectors for run_length_detector (CNT_W=4, MIN_RUN=2).
module tb_run_length_detector;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       b = 1'b0;
    logic       b_en = 1'b1;
    logic       len_ready = 1'b1;
    logic [3:0] len_o;
    logic       sat_o, len_valid, drop_o;
`ifdef RLD_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    run_length_detector #(.CNT_W(4), .MIN_RUN(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .b         (b),
        .b_en      (b_en),
        .len_o     (len_o),
        .sat_o     (sat_o),
        .len_valid (len_valid),
        .len_ready (len_ready),
        .drop_o    (drop_o)
`ifdef RLD_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic bv, input logic ev = 1'b1);
        b    = bv;
        b_en = ev;
        @(posedge clk);
        #1;
    endtask

    task automatic outs(input string tag, input int v, input int l, input int s, input int d);
        chk({tag, ".valid"}, 32'(len_valid), v);
        chk({tag, ".len"},   32'(len_o), l);
        chk({tag, ".sat"},   32'(sat_o), s);
        chk({tag, ".drop"},  32'(drop_o), d);
    endtask

    initial begin
        #1;
        outs("reset", 0, 0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;

        // 1: run of 3
        cyc(0); cyc(1); cyc(1); cyc(1);
        chk("t1.pre_valid", 32'(len_valid), 0);
        cyc(0);
        outs("t1", 1, 3, 0, 0);

        // 2: saturation, no wrap
        cyc(0);
        chk("t2.accepted", 32'(len_valid), 0);
        for (int i = 0; i < 20; i++) cyc(1);
        chk("t2.pre_valid", 32'(len_valid), 0);
        cyc(0);
        outs("t2", 1, 15, 1, 0);

        // 3: run shorter than MIN_RUN
        cyc(0);
        cyc(1); cyc(0);
        chk("t3.valid", 32'(len_valid), 0);
        chk("t3.drop", 32'(drop_o), 0);
        cyc(0);
        chk("t3.valid2", 32'(len_valid), 0);

        // 4: buffer full, second run dropped
        len_ready = 1'b0;
        for (int i = 0; i < 4; i++) cyc(1);
        cyc(0);
        outs("t4.first", 1, 4, 0, 0);
        for (int i = 0; i < 5; i++) cyc(1);
        chk("t4.mid_len", 32'(len_o), 4);
        cyc(0);
        outs("t4.drop", 1, 4, 0, 1);
`ifdef RLD_DROP_CNT_EN
        chk("t4.drop_cnt", 32'(drop_cnt), 1);
`endif
        cyc(0);
        outs("t4.after", 1, 4, 0, 0);
        len_ready = 1'b1;
        cyc(0);
        chk("t4.accept", 32'(len_valid), 0);
`ifdef RLD_DROP_CNT_EN
        chk("t4.drop_cnt_clr", 32'(drop_cnt), 0);
`endif

        // 5: b_en gap mid-run, then completion coinciding with accept
        cyc(1); cyc(1);
        for (int i = 0; i < 5; i++) cyc(0, 0);
        chk("t5.gap_valid", 32'(len_valid), 0);
        cyc(1); cyc(0);
        outs("t5.gap", 1, 3, 0, 0);
        len_ready = 1'b0;
        cyc(1); cyc(1);
        chk("t5.hold_len", 32'(len_o), 3);
        len_ready = 1'b1;
        cyc(0);
        outs("t5.swap", 1, 2, 0, 0);
        cyc(0);
        chk("t5.accept", 32'(len_valid), 0);

        // 6: async reset with pending report and open run
        len_ready = 1'b0;
        cyc(1); cyc(1); cyc(0);
        outs("t6.pending", 1, 2, 0, 0);
        cyc(1); cyc(1); cyc(1);
        #2 rst = 1'b0;
        #1;
        outs("t6.async", 0, 0, 0, 0);
        b = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        len_ready = 1'b1;
        cyc(1); cyc(1); cyc(0);
        outs("t6.after", 1, 2, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
